// File: rtl/multicore_dram_arbiter_if.sv
// Bus bundle between the shared-RAM arbiter and its surroundings: mode control,
// external load/dump port, per-core request ports and the RAM control port.
// The slave modport is the arbiter's view; master is the system/bench view.
interface multicore_dram_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9
);
  logic [1:0]                mode;
  logic [ADDR_W-1:0]         ext_addr;
  logic [DATA_W-1:0]         ext_wdata;
  logic                      ext_we;
  logic                      ext_re;
  logic [N_CORES*ADDR_W-1:0] core_addr;
  logic [N_CORES*DATA_W-1:0] core_wdata;
  logic [N_CORES-1:0]        core_we;
  logic [N_CORES-1:0]        core_re;
  logic [N_CORES-1:0]        core_grant;
  logic [N_CORES-1:0]        core_rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      ext_rvalid;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic                      mem_re;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  mode, ext_addr, ext_wdata, ext_we, ext_re,
    input  core_addr, core_wdata, core_we, core_re,
    input  mem_rdata,
    output core_grant, core_rvalid, rdata, ext_rvalid,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output mode, ext_addr, ext_wdata, ext_we, ext_re,
    output core_addr, core_wdata, core_we, core_re,
    output mem_rdata,
    input  core_grant, core_rvalid, rdata, ext_rvalid,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/multicore_dram_arbiter.sv
// Shares one single-port data RAM between N_CORES cores (round-robin in RUN)
// and an external load/dump port. Every RAM control, grant and valid output is
// registered; rdata is the RAM read data passed straight through, qualified by
// core_rvalid / ext_rvalid one cycle after the registered mem_re.
module multicore_dram_arbiter #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9
) (
  input logic                       clock,
  input logic                       reset,
  multicore_dram_arbiter_if.slave   bus
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_DUMP = 2'b11
  } mode_e;

  mode_e              mode;
  logic [N_CORES-1:0] req;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int                 scan_idx;
  int                 next_ptr;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_CORES-1:0] grant_q, grant_d;
  logic [N_CORES-1:0] rd_core_q, rd_core_d;
  logic [N_CORES-1:0] core_rvalid_q, core_rvalid_d;
  logic               rd_ext_q, rd_ext_d;
  logic               ext_rvalid_q, ext_rvalid_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;

  assign mode = mode_e'(bus.mode);

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    req       = bus.core_we | bus.core_re;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_CORES; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N_CORES) scan_idx = scan_idx - N_CORES;
      if (!win_found && req[PTR_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan_idx);
      end
    end
  end

  // Next-state for RAM controls, grants, pointer and the read-return pipeline.
  always_comb begin
    ptr_d         = ptr_q;
    grant_d       = '0;
    rd_core_d     = '0;
    rd_ext_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    // A read issued last cycle returns now, whatever the current mode.
    core_rvalid_d = rd_core_q;
    ext_rvalid_d  = rd_ext_q;
    next_ptr      = 0;

    case (mode)
      MODE_LOAD: begin
        ptr_d = '0;
        if (bus.ext_we) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.ext_addr;
          mem_wdata_d = bus.ext_wdata;
        end
      end
      MODE_DUMP: begin
        ptr_d = '0;
        if (bus.ext_re) begin
          mem_re_d   = 1'b1;
          rd_ext_d   = 1'b1;
          mem_addr_d = bus.ext_addr;
        end
      end
      MODE_RUN: begin
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          mem_addr_d       = bus.core_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d      = bus.core_wdata[int'(win_idx)*DATA_W +: DATA_W];
          mem_we_d         = bus.core_we[win_idx];
          // Write wins when a core raises both strobes; the read is dropped.
          mem_re_d           = bus.core_re[win_idx] & ~bus.core_we[win_idx];
          rd_core_d[win_idx] = mem_re_d;
          next_ptr = int'(win_idx) + 1;
          if (next_ptr >= N_CORES) next_ptr = 0;
          ptr_d = PTR_W'(next_ptr);
        end
      end
      default: begin
        // IDLE: no RAM activity; pointer parked at 0 so RUN entry starts there.
        ptr_d = '0;
      end
    endcase
  end

  // State and output registers; async reset also cancels any read in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q         <= '0;
      grant_q       <= '0;
      rd_core_q     <= '0;
      core_rvalid_q <= '0;
      rd_ext_q      <= 1'b0;
      ext_rvalid_q  <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      rd_core_q     <= rd_core_d;
      core_rvalid_q <= core_rvalid_d;
      rd_ext_q      <= rd_ext_d;
      ext_rvalid_q  <= ext_rvalid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
    end
  end

  assign bus.core_grant  = grant_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.ext_rvalid  = ext_rvalid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.rdata       = bus.mem_rdata;

endmodule

// File: tb/tb_multicore_dram_arbiter.sv
// Directed bench for multicore_dram_arbiter: a behavioural RAM answers the
// arbiter's mem_* port, expected read returns are queued as requests are
// issued and popped whenever an rvalid appears.
module tb_multicore_dram_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 9;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicore_dram_arbiter_if #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  multicore_dram_arbiter #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: read data valid the cycle after mem_re.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_rdata;
  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) ram_rdata <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          ext;
    logic [N-1:0]  cores;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic ext, input logic [N-1:0] c, input logic [DW-1:0] d);
    exp_t e;
    e.ext   = ext;
    e.cores = c;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_addr[i*AW +: AW]  = a;
    bus.core_wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  32'(bus.core_grant),  32'h0);
    chk({tag, "_rvalid"}, 32'(bus.core_rvalid), 32'h0);
    chk({tag, "_extrv"},  32'(bus.ext_rvalid),  32'h0);
    chk({tag, "_we"},     32'(bus.mem_we),      32'h0);
    chk({tag, "_re"},     32'(bus.mem_re),      32'h0);
    chk({tag, "_addr"},   32'(bus.mem_addr),    32'h0);
    chk({tag, "_wdata"},  32'(bus.mem_wdata),   32'h0);
  endtask

  // Scoreboard: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus.ext_rvalid || (|bus.core_rvalid)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rvalid observed=%0h expected=none",
               {bus.ext_rvalid, bus.core_rvalid});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_ext",   32'(bus.ext_rvalid),  32'(e.ext));
        chk("sb_cores", 32'(bus.core_rvalid), 32'(e.cores));
        chk("sb_data",  32'(bus.rdata),       32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           order [5];
    logic [N-1:0] oh;
    logic [N-1:0] prev_oh;
    int           w;

    reset          = 1'b1;
    bus.mode       = 2'b00;
    bus.ext_addr   = '0;
    bus.ext_wdata  = '0;
    bus.ext_we     = 1'b0;
    bus.ext_re     = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.core_we    = '0;
    bus.core_re    = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_we", 32'(bus.mem_we), 32'h0);

    // LOAD: preload core read targets, then the 0xBEEF word with ext_re ignored.
    bus.mode = 2'b01;
    for (int i = 0; i < N; i++) begin
      bus.ext_we    = 1'b1;
      bus.ext_addr  = AW'(9'h100 + i);
      bus.ext_wdata = DW'(16'hA000 + i);
      tick();
    end
    bus.ext_re    = 1'b1;
    bus.ext_addr  = 9'h005;
    bus.ext_wdata = 16'hBEEF;
    tick();
    chk("load_we",    32'(bus.mem_we),    32'h1);
    chk("load_addr",  32'(bus.mem_addr),  32'h005);
    chk("load_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    chk("load_re_ign", 32'(bus.mem_re),   32'h0);
    bus.ext_we = 1'b0;
    bus.ext_re = 1'b0;
    tick();
    chk("load_we_off", 32'(bus.mem_we), 32'h0);

    // DUMP: read back 0x005, ext_we ignored.
    bus.mode     = 2'b11;
    bus.ext_re   = 1'b1;
    bus.ext_we   = 1'b1;
    bus.ext_addr = 9'h005;
    push(1'b1, '0, 16'hBEEF);
    tick();
    chk("dump_re",     32'(bus.mem_re),     32'h1);
    chk("dump_we_ign", 32'(bus.mem_we),     32'h0);
    chk("dump_addr",   32'(bus.mem_addr),   32'h005);
    chk("dump_early",  32'(bus.ext_rvalid), 32'h0);
    bus.ext_re = 1'b0;
    bus.ext_we = 1'b0;
    tick();
    chk("dump_rvalid", 32'(bus.ext_rvalid), 32'h1);
    chk("dump_rdata",  32'(bus.rdata),      32'hBEEF);
    tick();
    chk("dump_rv_off", 32'(bus.ext_rvalid), 32'h0);

    // RUN: all cores reading -> 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_core(i, AW'(9'h100 + i), '0);
    order      = '{0, 1, 2, 3, 0};
    bus.mode   = 2'b10;
    bus.core_re = 4'hF;
    prev_oh    = '0;
    for (int k = 0; k < 5; k++) begin
      oh = N'(1) << order[k];
      push(1'b0, oh, DW'(16'hA000 + order[k]));
      tick();
      chk("rr4_grant", 32'(bus.core_grant), 32'(oh));
      chk("rr4_re",    32'(bus.mem_re),     32'h1);
      chk("rr4_addr",  32'(bus.mem_addr),   32'(9'h100 + order[k]));
      if (k > 0) chk("rr4_rvalid", 32'(bus.core_rvalid), 32'(prev_oh));
      prev_oh = oh;
    end
    bus.core_re = '0;
    tick();
    chk("rr4_tail_grant",  32'(bus.core_grant),  32'h0);
    chk("rr4_tail_rvalid", 32'(bus.core_rvalid), 32'(prev_oh));
    tick();

    // RUN: only cores 1 and 3 -> 1,3,1,3.
    bus.mode = 2'b00;
    tick();
    bus.mode    = 2'b10;
    bus.core_re = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      w  = (k % 2 == 0) ? 1 : 3;
      oh = N'(1) << w;
      push(1'b0, oh, DW'(16'hA000 + w));
      tick();
      chk("rr13_grant", 32'(bus.core_grant), 32'(oh));
    end
    bus.core_re = '0;
    tick();
    tick();

    // Core 2 write+read together: write only, no rvalid; then read it back.
    set_core(2, 9'h010, 16'h1234);
    bus.core_we = 4'b0100;
    bus.core_re = 4'b0100;
    tick();
    chk("rmw_grant", 32'(bus.core_grant), 32'h4);
    chk("rmw_we",    32'(bus.mem_we),     32'h1);
    chk("rmw_re",    32'(bus.mem_re),     32'h0);
    chk("rmw_addr",  32'(bus.mem_addr),   32'h010);
    chk("rmw_wdata", 32'(bus.mem_wdata),  32'h1234);
    bus.core_we = '0;
    bus.core_re = '0;
    tick();
    chk("rmw_no_rvalid", 32'(bus.core_rvalid), 32'h0);
    tick();
    bus.core_re = 4'b0100;
    push(1'b0, 4'b0100, 16'h1234);
    tick();
    chk("rb_grant", 32'(bus.core_grant), 32'h4);
    chk("rb_re",    32'(bus.mem_re),     32'h1);
    bus.core_re = '0;
    tick();
    chk("rb_rvalid", 32'(bus.core_rvalid), 32'h4);
    chk("rb_rdata",  32'(bus.rdata),       32'h1234);
    tick();

    // Core 0 read granted, then IDLE: rvalid still fires, requests ignored.
    bus.core_re = 4'b0001;
    push(1'b0, 4'b0001, 16'hA000);
    tick();
    chk("idle_sw_grant", 32'(bus.core_grant), 32'h1);
    bus.mode = 2'b00;
    tick();
    chk("idle_sw_rvalid", 32'(bus.core_rvalid), 32'h1);
    chk("idle_sw_nogrant", 32'(bus.core_grant), 32'h0);
    chk("idle_sw_re",     32'(bus.mem_re),     32'h0);
    chk("idle_sw_we",     32'(bus.mem_we),     32'h0);
    tick();
    chk("idle_sw_rv_off", 32'(bus.core_rvalid), 32'h0);
    chk("idle_sw_re2",    32'(bus.mem_re),      32'h0);
    chk("idle_sw_grant2", 32'(bus.core_grant),  32'h0);
    bus.core_re = '0;

    // Reset during back-to-back grants: immediate clear, pending read lost.
    bus.mode    = 2'b10;
    bus.core_re = 4'hF;
    push(1'b0, 4'b0001, 16'hA000);
    tick();
    chk("bb_grant0", 32'(bus.core_grant), 32'h1);
    tick();
    chk("bb_grant1", 32'(bus.core_grant), 32'h2);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clock);
    #1;
    reset       = 1'b0;
    bus.core_re = 4'b0110;
    push(1'b0, 4'b0010, 16'hA001);
    tick();
    chk("post_rst_grant", 32'(bus.core_grant), 32'h2);
    bus.core_re = '0;
    tick();
    chk("post_rst_rvalid", 32'(bus.core_rvalid), 32'h2);
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
